uart_tx: RTL and testbench
==========================

# uart_tx

Parametrised UART transmitter with an input byte FIFO. It serialises queued words onto a single `tx` line, LSB first, with configurable bit period, data width, parity and stop bits. It drives the `rx` pin of `cpu` in simulation benches and FPGA loopback builds, so programs and stimulus reach the core as real serial frames rather than forced nets.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame, 5–9.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 8: input FIFO entries; must be a power of two, ≥ 2.

- `clk` input 1: the block's only clock. All state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input DATA_BITS: word to transmit.
- `in_valid` input 1: `in_data` is presented.
- `in_ready` output 1: FIFO can accept a word. Equals !full.
- `tx` output 1: serial line; idles high.
- `busy` output 1: a frame is on the line, or the FIFO is non-empty.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.

## Operation
- Push: a word is written when `in_valid && in_ready` at a rising edge. While full, `in_valid` is ignored and the data is not latched.
- FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into a shift register, load the bit counter, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out DATA_BITS bits LSB first, each held CLKS_PER_BIT cycles. Then go to PARITY if PARITY≠0, otherwise STOP.
  - PARITY: one bit. Odd mode sends ~^data; even mode sends ^data.
  - STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles. Then pop the next word and go directly to START if the FIFO is non-empty, otherwise go to IDLE.
- Back-to-back frames have no idle gap: the start bit follows the last stop-bit cycle directly.
- Parity is computed on the popped word and held stable for the whole frame.
- Push and pop in the same cycle: both take effect and `fifo_count` is unchanged.
  - When the FIFO is full, a same-cycle pop does not open `in_ready` in that cycle. `in_ready` is a function of the current count only.
- Reset values: `tx`=1, `busy`=0, `in_ready`=1, `fifo_count`=0, FSM=IDLE, FIFO pointers 0.
- Reset mid-frame: `tx` returns high immediately (asynchronous). The FIFO is flushed and the partial frame is dropped. No frame resumes after reset deasserts.
- Arithmetic:
  - Baud counter is $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, and wraps at the bit boundary.
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Full/empty use a count register, not pointer comparison.

## Timing
- `tx` is driven from a flop; no combinational path from inputs to `tx`.
- Latency, with FIFO empty and FSM in IDLE:
  - Push at edge N. `fifo_count`=1 after edge N.
  - Pop at edge N+1. `tx` falls after edge N+1.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- `busy` falls in the same cycle the FSM re-enters IDLE with the FIFO empty.
- `in_ready` rises the cycle after a pop from a full FIFO.

## Structure
- Package `uart_pkg`:
  - `parity_e` enum: NONE, ODD, EVEN.
  - `tx_state_e` enum: IDLE, START, DATA, PARITY, STOP.
  - Shared constants used by a future `uart_rx`.
- Sub-module `sync_fifo`, parametrised by WIDTH and DEPTH, with ports `clk`, `rst`, push/pop, full/empty, and count.
  - `uart_tx` instantiates it with WIDTH=DATA_BITS.
  - It is reused by the planned receiver.

## Test plan
- Default parameters, CLKS_PER_BIT=4, push 0x55:
  - `tx` after reset is 1.
  - Bit sequence is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles.
  - Frame is 40 cycles; `busy` drops on cycle 42 after the push.
- PARITY=2 (even), push 0x07: the parity bit is 1. PARITY=1 (odd), push 0x07: the parity bit is 0. Frame is 11 bits.
- FIFO_DEPTH=4, STOP_BITS=2, six pushes in consecutive cycles of 0xA0..0xA5:
  - `in_ready` goes low after 5 accepted words (4 queued plus 1 in flight).
  - The sixth push is accepted after the first completed pop.
  - Frames go out with no idle gap, in order 0xA0..0xA5.
- DATA_BITS=5, push 0x1F then 0x00: the line carries exactly 5 data bits per frame. Bits 7:5 of the input are ignored.
- Assert `rst` during bit 3 of a frame with 3 words queued:
  - `tx` is 1 within the same cycle.
  - `fifo_count`=0 and `busy`=0.
  - After release, `tx` stays high for 100 cycles.
- With the FIFO full, hold `in_valid` while a pop occurs: no word is lost or duplicated, and the sent order matches the accepted order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmitter and the planned receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int unsigned MIN_CLKS_PER_BIT = 2;
  localparam int unsigned MIN_DATA_BITS    = 5;
  localparam int unsigned MAX_DATA_BITS    = 9;
  // Wide enough to index up to MAX_DATA_BITS data bits or two stop bits.
  localparam int unsigned BIT_CNT_W        = 4;

  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input parity_e mode);
    return (mode == ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and a count register for full/empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: queued words are framed (start, data LSB first, optional parity,
// stop) and shifted out on a registered tx line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);
  localparam parity_e PAR_MODE = parity_e'(PARITY[1:0]);

  tx_state_e              state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   tx_reg;
  logic                   bit_done;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_data;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE) || !fifo_empty;
  assign tx       = tx_reg;
  assign bit_done = (baud_cnt == BAUD_LAST);

  // A pop loads the next frame, either from idle or straight out of the last stop cycle.
  always_comb begin
    fifo_pop = 1'b0;
    unique case (state)
      IDLE:    fifo_pop = !fifo_empty;
      STOP:    fifo_pop = bit_done && (bit_cnt == STOP_LAST) && !fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx_reg   <= 1'b1;
    end else begin
      baud_cnt <= bit_done ? '0 : baud_cnt + BAUD_W'(1);
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (fifo_pop) begin
            shreg   <= fifo_data;
            par_bit <= parity_bit(MAX_DATA_BITS'(fifo_data), PAR_MODE);
            bit_cnt <= '0;
            tx_reg  <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            tx_reg  <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                tx_reg <= par_bit;
                state  <= uart_pkg::PARITY;
              end else begin
                tx_reg <= 1'b1;
                state  <= STOP;
              end
            end else begin
              tx_reg  <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        uart_pkg::PARITY: begin
          if (bit_done) begin
            tx_reg  <= 1'b1;
            bit_cnt <= '0;
            state   <= STOP;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (fifo_pop) begin
                shreg   <= fifo_data;
                par_bit <= parity_bit(MAX_DATA_BITS'(fifo_data), PAR_MODE);
                tx_reg  <= 1'b0;
                state   <= START;
              end else begin
                tx_reg <= 1'b1;
                state  <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        default: begin
          tx_reg <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: five parameter variants share one clock and reset.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] vld;
  logic [7:0] din [5];

  wire       tx0, tx1, tx2, tx3, tx4;
  wire       bz0, bz1, bz2, bz3, bz4;
  wire       rd0, rd1, rd2, rd3, rd4;
  wire [3:0] ct0, ct1, ct2, ct4;
  wire [2:0] ct3;

  wire [4:0] tx_v   = {tx4, tx3, tx2, tx1, tx0};
  wire [4:0] busy_v = {bz4, bz3, bz2, bz1, bz0};
  wire [4:0] rdy_v  = {rd4, rd3, rd2, rd1, rd0};
  wire [3:0] cnt_v [5];
  assign cnt_v[0] = ct0;
  assign cnt_v[1] = ct1;
  assign cnt_v[2] = ct2;
  assign cnt_v[3] = {1'b0, ct3};
  assign cnt_v[4] = ct4;

  uart_tx #(.CLKS_PER_BIT(4)) d0 (
    .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rd0),
    .tx(tx0), .busy(bz0), .fifo_count(ct0));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY(2)) d1 (
    .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rd1),
    .tx(tx1), .busy(bz1), .fifo_count(ct1));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY(1)) d2 (
    .clk(clk), .rst(rst), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rd2),
    .tx(tx2), .busy(bz2), .fifo_count(ct2));
  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(2)) d3 (
    .clk(clk), .rst(rst), .in_data(din[3]), .in_valid(vld[3]), .in_ready(rd3),
    .tx(tx3), .busy(bz3), .fifo_count(ct3));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(5)) d4 (
    .clk(clk), .rst(rst), .in_data(din[4][4:0]), .in_valid(vld[4]), .in_ready(rd4),
    .tx(tx4), .busy(bz4), .fifo_count(ct4));

  int   n_cmp = 0;
  int   n_bad = 0;
  logic rec_on = 1'b0;
  int   rec_sel = 0;
  logic rec_q [$];

  always @(negedge clk) if (rec_on) rec_q.push_back(tx_v[rec_sel]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares the recorded line, from its first low sample, against a bit string
  // (one char per serial bit), then expects idle high right after.
  task automatic check_rec(input string tag, input string exp, input int cpb);
    int   i0 = -1;
    int   idx;
    logic o;
    foreach (rec_q[i]) if (i0 < 0 && rec_q[i] === 1'b0) i0 = i;
    chk({tag, "_found"}, 32'(i0 >= 0), 1);
    if (i0 >= 0) begin
      for (int b = 0; b < exp.len(); b++) begin
        for (int c = 0; c < cpb; c++) begin
          idx = i0 + b * cpb + c;
          o = (idx < rec_q.size()) ? rec_q[idx] : 1'bx;
          chk($sformatf("%s_b%0d_c%0d", tag, b, c), o, 32'(exp[b] == "1"));
        end
      end
      idx = i0 + exp.len() * cpb;
      o = (idx < rec_q.size()) ? rec_q[idx] : 1'bx;
      chk({tag, "_idle_after"}, o, 1);
    end
  endtask

  task automatic wait_idle(input int idx, input string tag, input int budget);
    int w = 0;
    while (busy_v[idx] !== 1'b0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk(tag, 32'(w < budget), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic start_rec(input int sel);
    rec_sel = sel;
    rec_q.delete();
    rec_on = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int hi;
    string burst;
    rst = 1'b1;
    vld = '0;
    for (int i = 0; i < 5; i++) din[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_tx%0d", i), tx_v[i], 1);
      chk($sformatf("rst_busy%0d", i), busy_v[i], 0);
      chk($sformatf("rst_rdy%0d", i), rdy_v[i], 1);
      chk($sformatf("rst_cnt%0d", i), cnt_v[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // 8N1 frame of 0x55 with latency and busy timing
    start_rec(0);
    din[0] = 8'h55;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    chk("push_cnt", cnt_v[0], 1);
    chk("push_tx_high", tx_v[0], 1);
    chk("push_busy", busy_v[0], 1);
    @(negedge clk);
    chk("pop_tx_low", tx_v[0], 0);
    chk("pop_cnt", cnt_v[0], 0);
    repeat (39) @(negedge clk);
    chk("last_stop_busy", busy_v[0], 1);
    chk("last_stop_tx", tx_v[0], 1);
    @(negedge clk);
    chk("idle_busy", busy_v[0], 0);
    repeat (4) @(negedge clk);
    rec_on = 1'b0;
    check_rec("f55", "0101010101", 4);

    // Even and odd parity on 0x07
    start_rec(1);
    din[1] = 8'h07;
    vld[1] = 1'b1;
    @(negedge clk);
    vld[1] = 1'b0;
    wait_idle(1, "par_even_done", 200);
    rec_on = 1'b0;
    check_rec("par_even", "01110000011", 4);

    start_rec(2);
    din[2] = 8'h07;
    vld[2] = 1'b1;
    @(negedge clk);
    vld[2] = 1'b0;
    wait_idle(2, "par_odd_done", 200);
    rec_on = 1'b0;
    check_rec("par_odd", "01110000001", 4);

    // Five data bits: 0xFF (low bits 0x1F) then 0xE0 (low bits 0x00)
    start_rec(4);
    din[4] = 8'hFF;
    vld[4] = 1'b1;
    @(negedge clk);
    din[4] = 8'hE0;
    @(negedge clk);
    vld[4] = 1'b0;
    wait_idle(4, "db5_done", 300);
    rec_on = 1'b0;
    check_rec("db5", "01111110000001", 4);

    // Depth-4 FIFO, two stop bits, six pushes with in_valid held while full
    start_rec(3);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fill_rdy%0d", k), rdy_v[3], 1);
      din[3] = 8'(8'hA0 + k);
      vld[3] = 1'b1;
      @(negedge clk);
    end
    chk("full_rdy", rdy_v[3], 0);
    chk("full_cnt", cnt_v[3], 4);
    din[3] = 8'hA5;
    w = 0;
    while (rdy_v[3] !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("full_wait_cycles", w, 41);
    @(negedge clk);
    vld[3] = 1'b0;
    chk("push6_cnt", cnt_v[3], 4);
    wait_idle(3, "burst_done", 600);
    rec_on = 1'b0;
    chk("burst_cnt_empty", cnt_v[3], 0);
    burst = {"00000010111", "01000010111", "00100010111",
             "01100010111", "00010010111", "01010010111"};
    check_rec("burst", burst, 4);

    // Reset in the middle of a frame with three words queued
    for (int k = 0; k < 4; k++) begin
      din[0] = 8'(k * 8'h11);
      vld[0] = 1'b1;
      @(negedge clk);
    end
    vld[0] = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_rst_tx", tx_v[0], 0);
    chk("pre_rst_cnt", cnt_v[0], 3);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx_v[0], 1);
    chk("mid_rst_cnt", cnt_v[0], 0);
    chk("mid_rst_busy", busy_v[0], 0);
    chk("mid_rst_rdy", rdy_v[0], 1);
    #1 rst = 1'b0;
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx_v[0] === 1'b1 && busy_v[0] === 1'b0) hi++;
    end
    chk("post_rst_idle_cycles", hi, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
